// File: rtl/ledr_pwm_fader.sv
// PWM brightness and per-LED linear afterglow fade for the LEDR PIO pattern.
// A prescaled frame counter generates the PWM reference and a frame-rate decay strobe.
module ledr_pwm_fader #(
  parameter int N_LEDS        = 10,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 4,
  parameter int DECAY_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_LEDS-1:0]   pattern_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                enable,
  output logic [N_LEDS-1:0]   led_out,
  output logic                frame_tick
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DEC_W = (DECAY_PERIODS > 1) ? $clog2(DECAY_PERIODS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_PERIODS - 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DEC_W-1:0]    dec_cnt;
  logic [PWM_BITS-1:0] level [N_LEDS];

  logic step;
  logic wrap;
  logic decay_step;

  assign step       = (pre_cnt == PRE_LAST);
  assign wrap       = step && (pwm_cnt == '1);
  assign decay_step = wrap && (dec_cnt == DEC_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      dec_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      pre_cnt    <= step ? '0 : pre_cnt + PRE_W'(1);
      frame_tick <= wrap;
      if (step)
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wrap)
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DEC_W'(1);
    end
  end

  // NOTE: level is a small flop array, not RAM, so it is reset like any other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_LEDS; i++)
        level[i] <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (pattern_in[i])
          level[i] <= brightness;
        else if (decay_step && (level[i] != '0))
          level[i] <= level[i] - PWM_BITS'(1);
      end
    end
  end

  // Level 0 never lights; the top code still leaves one dark step per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++)
        led_out[i] <= enable && (pwm_cnt < level[i]);
    end
  end

endmodule

// File: tb/tb_ledr_pwm_fader.sv
// Randomized bench for ledr_pwm_fader: two parameterizations driven in lockstep,
// each compared every clock against a time-arithmetic reference model.
module tb_ledr_pwm_fader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pattern_in;
  logic [7:0] brightness;
  logic       enable;
  logic [9:0] led_a, led_b;
  logic       ft_a, ft_b;

  always #5 clk = ~clk;

  ledr_pwm_fader #(.N_LEDS(10), .PWM_BITS(8), .PRESCALE(4), .DECAY_PERIODS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .brightness(brightness),
    .enable(enable), .led_out(led_a), .frame_tick(ft_a));

  ledr_pwm_fader #(.N_LEDS(10), .PWM_BITS(8), .PRESCALE(1), .DECAY_PERIODS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .brightness(brightness),
    .enable(enable), .led_out(led_b), .frame_tick(ft_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: everything derives from t, the number of clocks since reset release.
  int         prescale [2] = '{4, 1};
  int         decay    [2] = '{2, 1};
  int         t;
  int         lvl   [2][10];
  logic [9:0] m_led [2];
  logic       m_ft  [2];

  function automatic int frame_len(int k);
    return prescale[k] * 256;
  endfunction

  function automatic bit is_wrap(int k, int tt);
    return (tt % frame_len(k)) == frame_len(k) - 1;
  endfunction

  function automatic bit is_decay(int k, int tt);
    return is_wrap(k, tt) && (((tt / frame_len(k)) % decay[k]) == decay[k] - 1);
  endfunction

  function automatic int pwm_pos(int k, int tt);
    return (tt / prescale[k]) % 256;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) lvl[k][i] = 0;
      m_led[k] = '0;
      m_ft[k]  = 1'b0;
    end
  endtask

  task automatic tick();
    int         nl [2][10];
    logic [9:0] nled [2];
    logic       nft  [2];
    for (int k = 0; k < 2; k++) begin
      nft[k] = is_wrap(k, t);
      for (int i = 0; i < 10; i++) begin
        nled[k][i] = enable && (pwm_pos(k, t) < lvl[k][i]);
        if (pattern_in[i])                          nl[k][i] = int'(brightness);
        else if (is_decay(k, t) && lvl[k][i] > 0)   nl[k][i] = lvl[k][i] - 1;
        else                                        nl[k][i] = lvl[k][i];
      end
    end
    @(posedge clk);
    #1;
    t++;
    for (int k = 0; k < 2; k++) begin
      m_led[k] = nled[k];
      m_ft[k]  = nft[k];
      for (int i = 0; i < 10; i++) lvl[k][i] = nl[k][i];
    end
    check("led_a", 32'(led_a), 32'(m_led[0]));
    check("ft_a",  32'(ft_a),  32'(m_ft[0]));
    check("led_b", 32'(led_b), 32'(m_led[1]));
    check("ft_b",  32'(ft_b),  32'(m_ft[1]));
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic hold_check();
    @(posedge clk);
    #1;
    check("rst_led_a", 32'(led_a), 32'h0);
    check("rst_ft_a",  32'(ft_a),  32'h0);
    check("rst_led_b", 32'(led_b), 32'h0);
    check("rst_ft_b",  32'(ft_b),  32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Step until the next edge is a decay edge for instance k, then raise bit0 on that edge.
  task automatic collide(input int k, input int budget);
    int n = 0;
    pattern_in = '0;
    while (!is_decay(k, t) && n < budget) begin
      tick();
      n++;
    end
    check("collide_found", 32'(is_decay(k, t)), 32'h1);
    pattern_in = 10'h001;
    tick();
    pattern_in = '0;
    run(3 * frame_len(k));
  endtask

  initial begin
    reset_n    = 1'b0;
    pattern_in = 10'h3FF;
    brightness = 8'd255;
    enable     = 1'b1;
    model_reset();
    repeat (4) hold_check();
    release_reset();
    run(2);
    check("t1_lit_a", 32'(led_a), 32'h3FF);
    check("t1_lit_b", 32'(led_b), 32'h3FF);
    run(1100);

    // Random pattern/brightness/enable segments with occasional mid-segment changes.
    for (int seg = 0; seg < 12; seg++) begin
      int len;
      case ($urandom_range(0, 3))
        0:       brightness = 8'd0;
        1:       brightness = 8'd255;
        2:       brightness = 8'($urandom_range(1, 4));
        default: brightness = 8'($urandom);
      endcase
      pattern_in = 10'($urandom);
      enable     = ($urandom_range(0, 4) != 0);
      len        = $urandom_range(100, 1500);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 63) == 0) brightness = 8'($urandom);
        if ($urandom_range(0, 63) == 0) pattern_in = pattern_in & 10'($urandom);
        tick();
      end
    end

    // Full fade from 4 down to 0 with saturation, on both decay rates.
    enable     = 1'b1;
    brightness = 8'd4;
    pattern_in = 10'h3FF;
    run(300);
    pattern_in = 10'h000;
    run(4 * 2048 + 1500);

    // Set versus decay_step in the same clock.
    brightness = 8'd9;
    pattern_in = 10'h3FF;
    run(50);
    collide(1, 600);
    pattern_in = 10'h3FF;
    run(50);
    collide(0, 3000);

    // Enable dropped mid-fade for 5 frames, then restored.
    brightness = 8'd20;
    pattern_in = 10'h3FF;
    run(300);
    pattern_in = 10'h2A5;
    run(500);
    enable = 1'b0;
    tick();
    check("en_off_a", 32'(led_a), 32'h0);
    check("en_off_b", 32'(led_b), 32'h0);
    run(5 * 1024);
    enable = 1'b1;
    run(3000);

    // Asynchronous reset mid-fade, then the PIO all-ones reset pattern.
    pattern_in = 10'h000;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_led_a", 32'(led_a), 32'h0);
    check("async_led_b", 32'(led_b), 32'h0);
    check("async_ft_a",  32'(ft_a),  32'h0);
    pattern_in = 10'h3FF;
    brightness = 8'd255;
    model_reset();
    repeat (3) hold_check();
    release_reset();
    run(2);
    check("rel_lit_a", 32'(led_a), 32'h3FF);
    check("rel_lit_b", 32'(led_b), 32'h3FF);
    run(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
